// File: rtl/ppg_pkg.sv
// ----------------------------------------------------------------------------
// ppg_pkg
// Shared definitions for the PPG front-end control blocks: data widths of the
// ADC / DC compensation / PGA gain buses, the slot timer width and the
// scheduler state encodings (also used by the calibration controller).
// ----------------------------------------------------------------------------
package ppg_pkg;

    localparam int ADC_W = 8;
    localparam int DC_W  = 7;
    localparam int PGA_W = 4;
    localparam int TMR_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RED_SET = 3'd1,
        ST_RED_ACQ = 3'd2,
        ST_IR_SET  = 3'd3,
        ST_IR_ACQ  = 3'd4,
        ST_DK_SET  = 3'd5,
        ST_DK_ACQ  = 3'd6,
        ST_PUBLISH = 3'd7
    } ppg_state_t;

endpackage

// File: rtl/ppg_slot_avg.sv
// ----------------------------------------------------------------------------
// ppg_slot_avg
// Box-average accumulator for one time slot.
// Ports:
//   CLK, rst_n : clock, asynchronous active-low reset
//   clr        : clear the accumulator
//   add        : accumulate din this cycle
//   din        : ADC sample
//   avg        : (acc + din) >> AVG_LOG2, i.e. the slot result when sampled on
//                the last acquisition cycle (includes that cycle's sample)
// ----------------------------------------------------------------------------
module ppg_slot_avg
    import ppg_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             add,
    input  logic [ADC_W-1:0] din,
    output logic [ADC_W-1:0] avg
);

    localparam int ACC_W = ADC_W + AVG_LOG2;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;

    // Sum of 2^AVG_LOG2 eight-bit samples is at most 255*2^AVG_LOG2, so ACC_W
    // bits are always enough and no saturation is needed.
    assign sum = acc + ACC_W'(din);
    assign avg = sum[ACC_W-1:AVG_LOG2];

    // Accumulator register
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (add) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/ppg_slot_scheduler.sv
// ----------------------------------------------------------------------------
// ppg_slot_scheduler
// Post-calibration LED/ADC slot scheduler. Repeats RED -> IR -> DARK frames;
// each slot settles SETTLE_CYC cycles then averages 2^AVG_LOG2 ADC samples.
// After the DARK slot all three averages are published with a 1-cycle strobe.
// Ports:
//   CLK, rst_n              : clock, asynchronous active-low reset
//   enable                  : run frames (looked at in IDLE and PUBLISH only)
//   red_dc/ir_dc            : calibrated DC compensation codes
//   red_pga/ir_pga          : calibrated PGA gain codes
//   ADC                     : ADC sample
//   LED_RED, LED_IR         : LED enables (never both high)
//   DC_Comp, PGA_Gain       : settings driven to the analog front end
//   RED/IR/DARK_ADC_Value   : averages of the last published frame
//   sample_valid            : 1-cycle pulse when the value outputs update
//   busy                    : high outside IDLE
// All outputs are registered from the next-state decode.
// ----------------------------------------------------------------------------
module ppg_slot_scheduler
    import ppg_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    parameter int AVG_LOG2   = 2
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [DC_W-1:0]  red_dc,
    input  logic [DC_W-1:0]  ir_dc,
    input  logic [PGA_W-1:0] red_pga,
    input  logic [PGA_W-1:0] ir_pga,
    input  logic [ADC_W-1:0] ADC,
    output logic             LED_RED,
    output logic             LED_IR,
    output logic [DC_W-1:0]  DC_Comp,
    output logic [PGA_W-1:0] PGA_Gain,
    output logic [ADC_W-1:0] RED_ADC_Value,
    output logic [ADC_W-1:0] IR_ADC_Value,
    output logic [ADC_W-1:0] DARK_ADC_Value,
    output logic             sample_valid,
    output logic             busy
);

    localparam logic [TMR_W-1:0] SET_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] ACQ_LAST = TMR_W'((1 << AVG_LOG2) - 1);

    ppg_state_t       state_q;
    ppg_state_t       state_d;
    logic [TMR_W-1:0] timer_q;
    logic             slot_done;
    logic             frame_start;

    logic [DC_W-1:0]  red_dc_sh;
    logic [DC_W-1:0]  ir_dc_sh;
    logic [PGA_W-1:0] red_pga_sh;
    logic [PGA_W-1:0] ir_pga_sh;
    logic [DC_W-1:0]  red_dc_eff;
    logic [PGA_W-1:0] red_pga_eff;

    logic             acc_clr;
    logic             acc_add;
    logic [ADC_W-1:0] slot_avg;
    logic [ADC_W-1:0] hold_red;
    logic [ADC_W-1:0] hold_ir;

    logic             led_red_d;
    logic             led_ir_d;
    logic [DC_W-1:0]  dc_d;
    logic [PGA_W-1:0] pga_d;
    logic             valid_d;
    logic             busy_d;

    assign slot_done   = (timer_q == '0);
    assign frame_start = (state_d == ST_RED_SET) && (state_q != ST_RED_SET);

    // State register
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a slot ends when the timer has counted down to zero
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (enable)    state_d = ST_RED_SET;
            ST_RED_SET: if (slot_done) state_d = ST_RED_ACQ;
            ST_RED_ACQ: if (slot_done) state_d = ST_IR_SET;
            ST_IR_SET:  if (slot_done) state_d = ST_IR_ACQ;
            ST_IR_ACQ:  if (slot_done) state_d = ST_DK_SET;
            ST_DK_SET:  if (slot_done) state_d = ST_DK_ACQ;
            ST_DK_ACQ:  if (slot_done) state_d = ST_PUBLISH;
            ST_PUBLISH: state_d = enable ? ST_RED_SET : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Slot timer: reloaded with (length-1) on every state change, so it reads
    // zero on the last cycle of the slot
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else if (state_d != state_q) begin
            if (state_d == ST_RED_SET || state_d == ST_IR_SET || state_d == ST_DK_SET) begin
                timer_q <= SET_LAST;
            end else begin
                timer_q <= ACQ_LAST;
            end
        end else if (!slot_done) begin
            timer_q <= timer_q - 1'b1;
        end
    end

    // Per-frame shadow copies of the calibration settings
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            red_dc_sh  <= '0;
            ir_dc_sh   <= '0;
            red_pga_sh <= '0;
            ir_pga_sh  <= '0;
        end else if (frame_start) begin
            red_dc_sh  <= red_dc;
            ir_dc_sh   <= ir_dc;
            red_pga_sh <= red_pga;
            ir_pga_sh  <= ir_pga;
        end
    end

    // On the edge that opens a frame the shadows are being loaded in parallel,
    // so the registered outputs take the inputs directly for that one edge
    assign red_dc_eff  = frame_start ? red_dc  : red_dc_sh;
    assign red_pga_eff = frame_start ? red_pga : red_pga_sh;

    assign acc_add = (state_q == ST_RED_ACQ) || (state_q == ST_IR_ACQ) || (state_q == ST_DK_ACQ);
    assign acc_clr = !acc_add;

    ppg_slot_avg #(
        .AVG_LOG2(AVG_LOG2)
    ) u_slot_avg (
        .CLK   (CLK),
        .rst_n (rst_n),
        .clr   (acc_clr),
        .add   (acc_add),
        .din   (ADC),
        .avg   (slot_avg)
    );

    // Slot result holds; the DARK result goes straight to its output at publish
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            hold_red <= '0;
            hold_ir  <= '0;
        end else begin
            if (state_q == ST_RED_ACQ && slot_done) hold_red <= slot_avg;
            if (state_q == ST_IR_ACQ  && slot_done) hold_ir  <= slot_avg;
        end
    end

    // Output decode from the next state; DC/PGA hold their value by default
    always_comb begin
        led_red_d = 1'b0;
        led_ir_d  = 1'b0;
        dc_d      = DC_Comp;
        pga_d     = PGA_Gain;
        valid_d   = (state_d == ST_PUBLISH);
        busy_d    = (state_d != ST_IDLE);
        case (state_d)
            ST_RED_SET, ST_RED_ACQ: begin
                led_red_d = 1'b1;
                dc_d      = red_dc_eff;
                pga_d     = red_pga_eff;
            end
            ST_IR_SET, ST_IR_ACQ: begin
                led_ir_d = 1'b1;
                dc_d     = ir_dc_sh;
                pga_d    = ir_pga_sh;
            end
            ST_DK_SET, ST_DK_ACQ: begin
                dc_d  = red_dc_sh;
                pga_d = red_pga_sh;
            end
            default: begin
            end
        endcase
    end

    // Output registers
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            LED_RED        <= 1'b0;
            LED_IR         <= 1'b0;
            DC_Comp        <= '0;
            PGA_Gain       <= '0;
            sample_valid   <= 1'b0;
            busy           <= 1'b0;
            RED_ADC_Value  <= '0;
            IR_ADC_Value   <= '0;
            DARK_ADC_Value <= '0;
        end else begin
            LED_RED      <= led_red_d;
            LED_IR       <= led_ir_d;
            DC_Comp      <= dc_d;
            PGA_Gain     <= pga_d;
            sample_valid <= valid_d;
            busy         <= busy_d;
            if (state_q == ST_DK_ACQ && state_d == ST_PUBLISH) begin
                RED_ADC_Value  <= hold_red;
                IR_ADC_Value   <= hold_ir;
                DARK_ADC_Value <= slot_avg;
            end
        end
    end

endmodule

// File: tb/tb_ppg_slot_scheduler.sv
// ----------------------------------------------------------------------------
// tb_ppg_slot_scheduler
// Scoreboard bench for ppg_slot_scheduler with default parameters
// (SETTLE_CYC=4, AVG_LOG2=2). Cycle k of a frame is the k-th clock period
// after the edge that samples enable: cycles 1-4 RED_SET, 5-8 RED_ACQ,
// 9-12 IR_SET, 13-16 IR_ACQ, 17-20 DK_SET, 21-24 DK_ACQ, 25 PUBLISH.
// ----------------------------------------------------------------------------
module tb_ppg_slot_scheduler;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] ir;
        logic [7:0] dark;
    } frame_t;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [6:0] red_dc, ir_dc;
    logic [3:0] red_pga, ir_pga;
    logic [7:0] ADC;
    logic       LED_RED, LED_IR;
    logic [6:0] DC_Comp;
    logic [3:0] PGA_Gain;
    logic [7:0] RED_ADC_Value, IR_ADC_Value, DARK_ADC_Value;
    logic       sample_valid, busy;

    frame_t     expQ[$];
    int         vecCount = 0;
    int         missCount = 0;
    logic [7:0] lastRed = 0, lastIr = 0, lastDark = 0;
    logic       prevValid = 1'b0;

    ppg_slot_scheduler dut (
        .CLK            (CLK),
        .rst_n          (rst_n),
        .enable         (enable),
        .red_dc         (red_dc),
        .ir_dc          (ir_dc),
        .red_pga        (red_pga),
        .ir_pga         (ir_pga),
        .ADC            (ADC),
        .LED_RED        (LED_RED),
        .LED_IR         (LED_IR),
        .DC_Comp        (DC_Comp),
        .PGA_Gain       (PGA_Gain),
        .RED_ADC_Value  (RED_ADC_Value),
        .IR_ADC_Value   (IR_ADC_Value),
        .DARK_ADC_Value (DARK_ADC_Value),
        .sample_valid   (sample_valid),
        .busy           (busy)
    );

    always #5 CLK = ~CLK;

    // Single comparison point: counts every check and reports a miscompare
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] mk4(input logic [7:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    // Truncated box average of four samples
    function automatic logic [7:0] avg4(input logic [31:0] s);
        logic [9:0] sum;
        sum = 10'(s[7:0]) + 10'(s[15:8]) + 10'(s[23:16]) + 10'(s[31:24]);
        return sum[9:2];
    endfunction

    // Continuous invariants: LEDs exclusive, valid never two cycles in a row
    always @(negedge CLK) begin
        if (rst_n === 1'b1) begin
            checkOutput("ledExcl", 32'(LED_RED & LED_IR), 0);
            checkOutput("validTwice", 32'(prevValid & sample_valid), 0);
        end
        prevValid = sample_valid;
    end

    // One frame. Entered just before the edge that samples enable=1.
    // eR*/eI* are the settings the frame should run with; chgSet changes the
    // inputs at cycle 10, dropEn clears enable at cycle 5, resetAt aborts.
    task automatic applyStimulus(input logic [31:0] rs, is, ds,
                                 input logic [6:0] eRdc, eIdc,
                                 input logic [3:0] eRpga, eIpga,
                                 input bit dropEn, input bit chgSet, input int resetAt);
        frame_t exp;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            @(negedge CLK);
            if (cyc == resetAt) begin
                rst_n  = 1'b0;
                enable = 1'b0;
                #1;
                checkOutput("rstCtl", {LED_RED, LED_IR, sample_valid, busy}, 0);
                checkOutput("rstDc", {DC_Comp, PGA_Gain}, 0);
                checkOutput("rstVal", {RED_ADC_Value, IR_ADC_Value, DARK_ADC_Value}, 0);
                lastRed = 0; lastIr = 0; lastDark = 0;
                @(negedge CLK);
                rst_n = 1'b1;
                break;
            end
            checkOutput("ledRed", 32'(LED_RED), 32'(cyc <= 8));
            checkOutput("ledIr", 32'(LED_IR), 32'(cyc >= 9 && cyc <= 16));
            checkOutput("busy", 32'(busy), 1);
            checkOutput("valid", 32'(sample_valid), 32'(cyc == 25));
            if (cyc <= 24) begin
                checkOutput("dcComp", 32'(DC_Comp), (cyc >= 9 && cyc <= 16) ? 32'(eIdc) : 32'(eRdc));
                checkOutput("pgaGain", 32'(PGA_Gain), (cyc >= 9 && cyc <= 16) ? 32'(eIpga) : 32'(eRpga));
                checkOutput("holdVals", {RED_ADC_Value, IR_ADC_Value, DARK_ADC_Value},
                            {lastRed, lastIr, lastDark});
            end else if (sample_valid && expQ.size() > 0) begin
                exp = expQ.pop_front();
                checkOutput("redVal", 32'(RED_ADC_Value), 32'(exp.red));
                checkOutput("irVal", 32'(IR_ADC_Value), 32'(exp.ir));
                checkOutput("darkVal", 32'(DARK_ADC_Value), 32'(exp.dark));
                lastRed = exp.red; lastIr = exp.ir; lastDark = exp.dark;
            end
            if (cyc >= 5 && cyc <= 8)        ADC = rs[(cyc-5)*8 +: 8];
            else if (cyc >= 13 && cyc <= 16) ADC = is[(cyc-13)*8 +: 8];
            else if (cyc >= 21 && cyc <= 24) ADC = ds[(cyc-21)*8 +: 8];
            else                             ADC = 8'($urandom_range(0, 255));
            if (cyc == 24) expQ.push_back('{red: avg4(rs), ir: avg4(is), dark: avg4(ds)});
            if (dropEn && cyc == 5) enable = 1'b0;
            if (chgSet && cyc == 10) begin
                red_dc = 7'd12; red_pga = 4'd1; ir_dc = 7'd120; ir_pga = 4'd15;
            end
        end
    endtask

    task automatic idleCheck(input int n, input logic [6:0] eDc, input logic [3:0] ePga);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            checkOutput("idleBusy", 32'(busy), 0);
            checkOutput("idleCtl", {LED_RED, LED_IR, sample_valid}, 0);
            checkOutput("idleDc", {DC_Comp, PGA_Gain}, {eDc, ePga});
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; ADC = 8'd0;
        red_dc = 7'd40; red_pga = 4'd3; ir_dc = 7'd90; ir_pga = 4'd7;
        repeat (2) @(negedge CLK);
        checkOutput("resetCtl", {LED_RED, LED_IR, sample_valid, busy}, 0);
        checkOutput("resetDc", {DC_Comp, PGA_Gain}, 0);
        checkOutput("resetVal", {RED_ADC_Value, IR_ADC_Value, DARK_ADC_Value}, 0);
        rst_n = 1'b1;
        idleCheck(2, 7'd0, 4'd0);

        // Constant ADC, two back-to-back frames (period 25)
        enable = 1'b1;
        applyStimulus(mk4(100,100,100,100), mk4(100,100,100,100), mk4(100,100,100,100),
                      7'd40, 7'd90, 4'd3, 4'd7, 0, 0, 0);
        applyStimulus(mk4(100,100,100,100), mk4(100,100,100,100), mk4(100,100,100,100),
                      7'd40, 7'd90, 4'd3, 4'd7, 0, 0, 0);
        // Distinct level per slot
        applyStimulus(mk4(200,200,200,200), mk4(50,50,50,50), mk4(10,10,10,10),
                      7'd40, 7'd90, 4'd3, 4'd7, 0, 0, 0);
        // Truncation, enable drop at cycle 5, settings changed at cycle 10
        applyStimulus(mk4(10,11,12,14), mk4(0,1,2,3), mk4(255,255,255,254),
                      7'd40, 7'd90, 4'd3, 4'd7, 1, 1, 0);
        idleCheck(5, 7'd40, 4'd3);

        // Restart: the new settings take effect from this frame
        enable = 1'b1;
        applyStimulus(mk4(1,2,3,4), mk4(255,0,255,0), mk4(7,7,7,8),
                      7'd12, 7'd120, 4'd1, 4'd15, 0, 0, 0);
        // Reset at cycle 12 of the next frame: nothing published
        applyStimulus(mk4(90,90,90,90), mk4(90,90,90,90), mk4(90,90,90,90),
                      7'd12, 7'd120, 4'd1, 4'd15, 0, 0, 12);
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            checkOutput("postRstValid", 32'(sample_valid), 0);
            checkOutput("postRstBusy", 32'(busy), 0);
        end
        checkOutput("sbLeft", 32'(expQ.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
